// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with req/flush; optional 2-entry skid buffer via PIPE_SKID_EN
module pipe_stage_reg #(
    parameter int          DATA_W   = 96,
    parameter int          EXC_W    = 5,
    parameter logic [31:0] PC_INIT  = 32'h0000_3000,
    parameter logic [31:0] EXC_ADDR = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_PC,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_wr_num,
    input  logic              in_wr_en,
    input  logic [EXC_W-1:0]  in_ExcCode,
    input  logic              in_BD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_PC,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_wr_num,
    output logic              out_wr_en,
    output logic [EXC_W-1:0]  out_ExcCode,
    output logic              out_BD
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [DATA_W-1:0] data;
        logic [4:0]        wr_num;
        logic              wr_en;
        logic [EXC_W-1:0]  exc_code;
        logic              bd;
    } entry_t;

    // A nop that still carries PC/BD so EPC and branch-delay info survive downstream.
    function automatic entry_t bubble(input logic [31:0] pc, input logic bd);
        entry_t e;
        e    = '0;
        e.pc = pc;
        e.bd = bd;
        return e;
    endfunction

    entry_t in_e;
    entry_t acc_e;
    entry_t m_q;
    entry_t m_d;
    logic   m_valid_q;
    logic   m_valid_d;
    logic   accept;
    logic   pop;

    always_comb begin
        in_e.instr    = in_instr;
        in_e.pc       = in_PC;
        in_e.data     = in_data;
        in_e.wr_num   = in_wr_num;
        in_e.wr_en    = in_wr_en;
        in_e.exc_code = in_ExcCode;
        in_e.bd       = in_BD;
        acc_e         = flush ? bubble(in_PC, in_BD) : in_e;
    end

    assign accept = in_valid & in_ready & ~req;
    assign pop    = m_valid_q & out_ready;

`ifdef PIPE_SKID_EN
    entry_t s_q;
    entry_t s_d;
    logic   s_valid_q;
    logic   s_valid_d;

    assign in_ready = ~s_valid_q;

    always_comb begin
        m_d       = m_q;
        m_valid_d = m_valid_q;
        s_d       = s_q;
        s_valid_d = s_valid_q;
        if (req) begin
            m_d       = bubble(EXC_ADDR, 1'b0);
            m_valid_d = 1'b1;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || pop) begin
            if (s_valid_q) begin
                // Oldest entry (S) moves up first; a same-cycle accept backfills S.
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = accept;
                if (accept) begin
                    s_d = acc_e;
                end
            end else if (accept) begin
                m_d       = acc_e;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_d       = acc_e;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q       <= '0;
            s_valid_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
        end
    end
`else
    assign in_ready = ~m_valid_q | out_ready;

    always_comb begin
        m_d       = m_q;
        m_valid_d = m_valid_q;
        if (req) begin
            m_d       = bubble(EXC_ADDR, 1'b0);
            m_valid_d = 1'b1;
        end else if (!m_valid_q || pop) begin
            if (accept) begin
                m_d       = acc_e;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q       <= bubble(PC_INIT, 1'b0);
            m_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign out_valid   = m_valid_q;
    assign out_instr   = m_q.instr;
    assign out_PC      = m_q.pc;
    assign out_data    = m_q.data;
    assign out_wr_num  = m_q.wr_num;
    assign out_wr_en   = m_q.wr_en;
    assign out_ExcCode = m_q.exc_code;
    assign out_BD      = m_q.bd;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg (default and PIPE_SKID_EN builds)
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int EXC_W  = 5;

    logic              clk = 1'b0;
    logic              reset, req, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]       in_instr, in_PC, out_instr, out_PC;
    logic [DATA_W-1:0] in_data, out_data;
    logic [4:0]        in_wr_num, out_wr_num;
    logic              in_wr_en, out_wr_en, in_BD, out_BD;
    logic [EXC_W-1:0]  in_ExcCode, out_ExcCode;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    pipe_stage_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W)) dut (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_PC(in_PC), .in_data(in_data),
        .in_wr_num(in_wr_num), .in_wr_en(in_wr_en), .in_ExcCode(in_ExcCode), .in_BD(in_BD),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_PC(out_PC), .out_data(out_data),
        .out_wr_num(out_wr_num), .out_wr_en(out_wr_en), .out_ExcCode(out_ExcCode), .out_BD(out_BD)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid   = v;
        in_instr   = instr;
        in_PC      = pc;
        in_data    = {32'hA5A5_0000, instr, pc};
        in_wr_num  = instr[4:0];
        in_wr_en   = 1'b1;
        in_ExcCode = 5'd2;
        in_BD      = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        step();
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_pc", out_PC, 32'h0000_3000);
        check_eq("rst_instr", out_instr, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_wr_en", out_wr_en, 0);
        check_eq("rst_bd", out_BD, 0);
        check_eq("rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0001, 32'h0000_3004);
        step();
        check_eq("first_valid", out_valid, 1);
        check_eq("first_instr", out_instr, 32'h1);
        check_eq("first_pc", out_PC, 32'h3004);
        check_eq("first_data", out_data, {32'hA5A5_0000, 32'h1, 32'h3004});

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + i, 32'h3100 + 4 * i);
            step();
            check_eq($sformatf("stream%0d_valid", i), out_valid, 1);
            check_eq($sformatf("stream%0d_instr", i), out_instr, 32'h10 + i);
            check_eq($sformatf("stream%0d_pc", i), out_PC, 32'h3100 + 4 * i);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        check_eq("drain_valid", out_valid, 0);

        drive(1'b1, 32'hDEAD_BEEF, 32'h0000_3010);
        flush = 1'b1; in_BD = 1'b1; in_wr_num = 5'd7; in_ExcCode = 5'd3;
        step();
        check_eq("flush_instr", out_instr, 0);
        check_eq("flush_wr_en", out_wr_en, 0);
        check_eq("flush_wr_num", out_wr_num, 0);
        check_eq("flush_exc", out_ExcCode, 0);
        check_eq("flush_data", out_data, 0);
        check_eq("flush_pc", out_PC, 32'h3010);
        check_eq("flush_bd", out_BD, 1);

        // Backpressure: output must hold, flush without accept does nothing.
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_pc", out_PC, 32'h3010);
        check_eq("hold_bd", out_BD, 1);
        check_eq("hold_in_ready", in_ready, SKID ? 1 : 0);
        out_ready = 1'b1;
        #1;
        check_eq("comb_in_ready", in_ready, 1);
        flush = 1'b0;

`ifdef PIPE_SKID_EN
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 32'h3020);
        step();
        check_eq("skid_m_hold", out_PC, 32'h3010);
        check_eq("skid_in_ready", in_ready, 0);
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check_eq("skid_second_valid", out_valid, 1);
        check_eq("skid_second_pc", out_PC, 32'h3020);
        check_eq("skid_second_instr", out_instr, 32'h20);
        check_eq("skid_ready_back", in_ready, 1);
        step();
        check_eq("skid_empty", out_valid, 0);
`else
        step();
        check_eq("pop_flush_valid", out_valid, 0);
`endif

        out_ready = 1'b0;
        drive(1'b1, 32'h30, 32'h3030);
        step();
        check_eq("pre_req_pc", out_PC, 32'h3030);
`ifdef PIPE_SKID_EN
        drive(1'b1, 32'h34, 32'h3034);
        step();
        check_eq("pre_req_full", in_ready, 0);
`endif
        drive(1'b1, 32'h40, 32'h3040);
        req = 1'b1;
        step();
        req = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check_eq("req_valid", out_valid, 1);
        check_eq("req_pc", out_PC, 32'h0000_4180);
        check_eq("req_instr", out_instr, 0);
        check_eq("req_wr_en", out_wr_en, 0);
        check_eq("req_bd", out_BD, 0);
        check_eq("req_in_ready", in_ready, SKID ? 1 : 0);
        out_ready = 1'b1;
        step();
        check_eq("req_s_discarded", out_valid, 0);

        out_ready = 1'b0;
        drive(1'b1, 32'h50, 32'h3050);
        step();
`ifdef PIPE_SKID_EN
        drive(1'b1, 32'h54, 32'h3054);
        step();
`endif
        check_eq("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        drive(1'b1, 32'h58, 32'h3058);
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_pc", out_PC, 32'h3000);
        check_eq("midrst_instr", out_instr, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        check_eq("midrst_s_empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
